// File: rtl/seg7_display.sv
// Eight-digit multiplexed 7-segment display controller with CPU-writable digit
// data, per-digit enable/decimal point, and blanking dead time at each slot start.
module seg7_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data_output,
  output logic [7:0]  digit_sel,
  output logic [7:0]  segment
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD    = CNT_W'(DEAD_CYCLES);

  localparam logic [2:0] ADDR_LO   = 3'b000;
  localparam logic [2:0] ADDR_HI   = 3'b010;
  localparam logic [2:0] ADDR_CTRL = 3'b100;

  logic [15:0]      data_lo_q, data_lo_d;
  logic [15:0]      data_hi_q, data_hi_d;
  logic [15:0]      ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             started_q;
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;

  logic [31:0] digits;
  logic [3:0]  nibble;
  logic [7:0]  dig_en;
  logic [7:0]  dp_en;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // The first edge after reset enters slot 0 at cnt 0 instead of advancing,
  // so digit 0 gets its full dead time and a full-length slot.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!started_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs use the post-edge position but pre-edge register contents.
  assign digits = {data_hi_q, data_lo_q};
  assign nibble = digits[{idx_d, 2'b00} +: 4];
  assign dig_en = ctrl_q[7:0];
  assign dp_en  = ctrl_q[15:8];

  always_comb begin
    sel_d = 8'hFF;
    seg_d = 8'hFF;
    if (cnt_d >= DEAD && dig_en[idx_d]) begin
      sel_d = ~(8'h01 << idx_d);
      seg_d = {~dp_en[idx_d], hex7(nibble)};
    end
  end

  always_comb begin
    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    ctrl_d    = ctrl_q;
    if (write_enable) begin
      case (address)
        ADDR_LO:   data_lo_d = write_data;
        ADDR_HI:   data_hi_d = write_data;
        ADDR_CTRL: ctrl_d    = write_data;
        default:   ;
      endcase
    end
  end

  always_comb begin
    read_data_output = 16'h0000;
    if (read_enable) begin
      case (address)
        ADDR_LO:   read_data_output = data_lo_q;
        ADDR_HI:   read_data_output = data_hi_q;
        ADDR_CTRL: read_data_output = ctrl_q;
        default:   read_data_output = 16'h0000;
      endcase
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      data_lo_q <= 16'h0000;
      data_hi_q <= 16'h0000;
      ctrl_q    <= 16'h00FF;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      started_q <= 1'b0;
      sel_q     <= 8'hFF;
      seg_q     <= 8'hFF;
    end else begin
      data_lo_q <= data_lo_d;
      data_hi_q <= data_hi_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      started_q <= 1'b1;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign digit_sel = sel_q;
  assign segment   = seg_q;

endmodule

// File: tb/tb_seg7_display.sv
// Directed bench for seg7_display with SCAN_DIV = 8, DEAD_CYCLES = 2.
module tb_seg7_display;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data_output;
  logic [7:0]  digit_sel;
  logic [7:0]  segment;

  int checks = 0;
  int errors = 0;
  int e = 0;
  logic [7:0] sel_t [8];
  logic [7:0] seg_t [8];

  seg7_display #(.SCAN_DIV(8), .DEAD_CYCLES(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .address          (address),
    .write_data       (write_data),
    .read_data_output (read_data_output),
    .digit_sel        (digit_sel),
    .segment          (segment)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
    e++;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    write_enable = 1'b1;
    address      = a;
    write_data   = d;
    step();
    write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    read_enable = 1'b1;
    address     = a;
    #1;
    chk(tag, read_data_output, exp);
    read_enable = 1'b0;
  endtask

  task automatic align_to(input int pos);
    int guard = 0;
    while (((e - 1) % 64) != pos && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) chk("align_timeout", 16'(guard), 16'd0);
  endtask

  task automatic scan(input string tag, input int n);
    int c;
    int ix;
    for (int k = 0; k < n; k++) begin
      step();
      c  = (e - 1) % 8;
      ix = ((e - 1) / 8) % 8;
      if (c < 2) begin
        chk({tag, "_sel_blank"}, {8'h00, digit_sel}, 16'h00FF);
        chk({tag, "_seg_blank"}, {8'h00, segment},   16'h00FF);
      end else begin
        chk({tag, "_sel"}, {8'h00, digit_sel}, {8'h00, sel_t[ix]});
        chk({tag, "_seg"}, {8'h00, segment},   {8'h00, seg_t[ix]});
      end
    end
  endtask

  initial begin
    reset = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    address = 3'b000; write_data = 16'h0000;

    // Reset held low
    repeat (3) @(negedge clock);
    #1;
    chk("rst_sel", {8'h00, digit_sel}, 16'h00FF);
    chk("rst_seg", {8'h00, segment},   16'h00FF);
    rd("rst_rd_lo",   3'b000, 16'h0000);
    rd("rst_rd_hi",   3'b010, 16'h0000);
    rd("rst_rd_ctrl", 3'b100, 16'h00FF);
    reset = 1'b1;
    e = 0;

    step(); chk("rel1_sel", {8'h00, digit_sel}, 16'h00FF);
            chk("rel1_seg", {8'h00, segment},   16'h00FF);
    step(); chk("rel2_sel", {8'h00, digit_sel}, 16'h00FF);
            chk("rel2_seg", {8'h00, segment},   16'h00FF);
    step(); chk("rel3_sel", {8'h00, digit_sel}, 16'h00FE);
            chk("rel3_seg", {8'h00, segment},   16'h00C0);

    // Full scan of 0..7, plus the wrap back to digit 0
    wr(3'b000, 16'h3210);
    wr(3'b010, 16'h7654);
    sel_t = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    align_to(63);
    scan("full", 72);

    // Digit enable and decimal point
    wr(3'b100, 16'h0405);
    sel_t = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    seg_t = '{8'hC0, 8'hFF, 8'h24, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    align_to(63);
    scan("en_dp", 64);

    // Hex letters
    wr(3'b100, 16'h00FF);
    wr(3'b000, 16'hFEDC);
    wr(3'b010, 16'hBA98);
    sel_t = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_t = '{8'hC6, 8'hA1, 8'h86, 8'h8E, 8'h80, 8'h90, 8'h88, 8'h83};
    align_to(63);
    scan("hex", 64);

    // Readback and unmapped address
    wr(3'b000, 16'hBEEF);
    rd("rb_lo", 3'b000, 16'hBEEF);
    wr(3'b110, 16'h1234);
    rd("bad_rd",     3'b110, 16'h0000);
    rd("bad_lo",     3'b000, 16'hBEEF);
    rd("bad_hi",     3'b010, 16'hBA98);
    rd("bad_ctrl",   3'b100, 16'h00FF);
    rd("unmapped1",  3'b001, 16'h0000);
    address = 3'b000;
    #1;
    chk("rd_disabled", read_data_output, 16'h0000);

    // Write visible one edge after capture
    align_to(3);
    chk("lat_pre_seg", {8'h00, segment}, 16'h008E);
    wr(3'b000, 16'h0000);
    chk("lat_same_edge_seg", {8'h00, segment}, 16'h008E);
    step();
    chk("lat_next_edge_seg", {8'h00, segment}, 16'h00C0);

    // Write on the slot-change edge
    align_to(7);
    chk("slot_pre_sel", {8'h00, digit_sel}, 16'h00FE);
    wr(3'b000, 16'h0050);
    chk("slot_chg_sel", {8'h00, digit_sel}, 16'h00FF);
    step();
    chk("slot_c1_sel", {8'h00, digit_sel}, 16'h00FF);
    step();
    chk("slot_c2_sel", {8'h00, digit_sel}, 16'h00FD);
    chk("slot_c2_seg", {8'h00, segment},   16'h0092);

    // Mid-scan reset at idx 5, cnt 4
    align_to(44);
    chk("mid_sel", {8'h00, digit_sel}, 16'h00DF);
    chk("mid_seg", {8'h00, segment},   16'h0090);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_sel", {8'h00, digit_sel}, 16'h00FF);
    chk("mid_rst_seg", {8'h00, segment},   16'h00FF);
    rd("mid_rst_lo",   3'b000, 16'h0000);
    rd("mid_rst_hi",   3'b010, 16'h0000);
    rd("mid_rst_ctrl", 3'b100, 16'h00FF);
    repeat (2) @(negedge clock);
    #1;
    chk("mid_hold_sel", {8'h00, digit_sel}, 16'h00FF);
    reset = 1'b1;
    e = 0;
    step(); chk("mid_rel1_sel", {8'h00, digit_sel}, 16'h00FF);
    step(); chk("mid_rel2_sel", {8'h00, digit_sel}, 16'h00FF);
    step(); chk("mid_rel3_sel", {8'h00, digit_sel}, 16'h00FE);
            chk("mid_rel3_seg", {8'h00, segment},   16'h00C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_display.md
Name: seg7_display

Overview:
- CPU-writable 8-digit multiplexed 7-segment display controller. It is the output-side counterpart of the keypad scanner.
- The CPU writes hex digit data and control bits over the I/O bus. The block cycles through the digits with active-low digit selects and active-low segment lines.
- It inserts blanking dead time at each digit change to suppress ghosting.
- It sits on the I/O bus beside the keypad block at 0xFFFFFC00-0xFFFFFC04.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit slot lasts (≥ 4).
- DEAD_CYCLES, 2, blank cycles at the start of each digit slot (1 ≤ DEAD_CYCLES < SCAN_DIV).

Ports:
- clock  input  1  system clock; all sequential logic updates on the falling edge.
- reset  input  1  asynchronous, active-low reset.
- write_enable  input  1  bus write strobe.
- read_enable  input  1  bus read strobe.
- address  input  3  register select within the block.
- write_data  input  16  write data from the CPU.
- read_data_output  output  16  register readback to the CPU.
- digit_sel  output  8  active-low digit enables; bit i drives digit i.
- segment  output  8  active-low segments; [6:0] = g..a, [7] = dp.

Behaviour:
- Registers:
  - data_low (address 000): digits 3..0, 4 bits each; digit0 = [3:0].
  - data_high (address 010): digits 7..4; digit4 = [3:0].
  - ctrl (address 100): [7:0] digit enable, [15:8] decimal point on.
- Register reset values: data_low = 0, data_high = 0, ctrl = 16'h00FF.
- Writes:
  - Captured on the falling edge when write_enable = 1.
  - Writes to any other address are ignored.
- Reads:
  - Combinational. With read_enable = 1 and address 000/010/100, read_data_output returns the matching register.
  - Otherwise read_data_output is 16'h0000. No latch is inferred.
- Scan counters: cnt counts 0..SCAN_DIV-1; idx counts 0..7.
  - At each falling edge, cnt increments.
  - When cnt = SCAN_DIV-1: cnt → 0 and idx → idx+1, with 7 wrapping to 0.
- Outputs are registered. At each falling edge they are computed from the post-edge cnt/idx values and the pre-edge register contents, so a write on edge N is visible on the outputs from edge N+1.
- Blanking rule:
  - If new cnt < DEAD_CYCLES, or ctrl[idx] = 0: digit_sel = 8'hFF and segment = 8'hFF.
  - Otherwise: digit_sel = ~(8'h01 << idx), and segment = {~ctrl[8+idx], hex7(nibble idx)}.
- hex7 patterns (active-low, [6:0]), digits 0..F:
  - 0-7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8-F: 00, 10, 08, 03, 46, 21, 06, 0E
- At most one digit_sel bit is low at any time. digit_sel and segment change only on falling edges.
- Reset:
  - Asserting reset at any time forces cnt = 0, idx = 0, digit_sel = 8'hFF, segment = 8'hFF, and all registers to their reset values, immediately and without waiting for a clock edge.
  - After release, scanning restarts from digit 0. The first DEAD_CYCLES edges are blank.
- Simultaneous write and slot change on the same edge: the old value is shown for that edge's output and the new value from the next edge. No glitch or skipped digit is allowed.
- An interrupt is not generated. The block is output-only apart from readback.

Test Plan:
All scenarios use SCAN_DIV = 8 and DEAD_CYCLES = 2.
- Reset check: hold reset low, then release. While reset is low, digit_sel = FF, segment = FF, and reads at 000/010/100 return 0000/0000/00FF. First non-blank output is on the 3rd falling edge after release, with digit_sel = FE and segment = C0.
- Full scan: write data_low = 16'h3210 and data_high = 16'h7654.
  - Over 64 edges, each digit i shows for 6 cycles after 2 blank cycles.
  - digit_sel = FE, FD, FB, F7, EF, DF, BF, 7F in turn, with segment = C0, F9, A4, B0, 99, 92, 82, F8.
  - The sequence then wraps to digit 0.
- Enable and decimal point: write ctrl = 16'h0405.
  - Digits 0 and 2 are lit; all other slots give digit_sel = FF.
  - Digit 2 with data nibble 2 shows segment = 24 (dp low).
  - Digit 0 shows C0 (dp high).
- Hex letters: write data_low = 16'hFEDC and data_high = 16'hBA98. Segments for digits 0..7 must be C6, A1, 86, 8E, 80, 90, 88, 83.
- Write/readback and boundary:
  - Write 16'hBEEF to address 000 and read it back as BEEF.
  - A write to address 110 leaves all registers unchanged and reads as 0000.
  - A write landing on the slot-change edge takes effect on the next edge.
- Mid-scan reset: assert reset at idx = 5, cnt = 4. Outputs go to FF immediately, and after release scanning resumes at digit 0 with registers at their reset values.
